// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES block UART transmitter.
// Holds the bit-engine state encoding and the frame/block sizes.
package aes_uart_pkg;

    localparam int unsigned UART_FRAME_BITS = 10;
    localparam int unsigned AES_BLOCK_BITS  = 128;
    localparam int unsigned BYTE_BITS       = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 bit engine: start bit, eight data bits LSB first, stop bit.
// A new byte can be taken on the last stop-bit cycle so frames abut with no gap.
module uart_tx_byte
    import aes_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         r_state, w_state_d;
    logic [BAUD_W-1:0] r_baud, w_baud_d;
    logic [2:0]        r_bit, w_bit_d;
    logic [7:0]        r_data, w_data_d;
    logic              r_tx, w_tx_d;
    logic              w_baud_last;
    logic              w_load;

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign o_ready     = (r_state == StIdle) || ((r_state == StStop) && w_baud_last);
    assign w_load      = o_ready && i_valid;
    assign o_tx        = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_baud  <= w_baud_d;
            r_bit   <= w_bit_d;
            r_data  <= w_data_d;
            r_tx    <= w_tx_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_valid) w_state_d = StStart;
            StStart: if (w_baud_last) w_state_d = StData;
            StData:  if (w_baud_last && (r_bit == 3'd7)) w_state_d = StStop;
            StStop:  if (w_baud_last) w_state_d = i_valid ? StStart : StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_baud_d = ((r_state == StIdle) || w_baud_last) ? '0 : r_baud + 1'b1;
        w_bit_d  = r_bit;
        if (r_state == StStart) begin
            w_bit_d = '0;
        end else if ((r_state == StData) && w_baud_last) begin
            w_bit_d = r_bit + 3'd1;
        end
        w_data_d = w_load ? i_data : r_data;
    end

    // Line level is derived from the next state so o_tx leaves a flop.
    always_comb begin
        w_tx_d = 1'b1;
        unique case (w_state_d)
            StStart: w_tx_d = 1'b0;
            StData:  w_tx_d = w_data_d[w_bit_d];
            default: w_tx_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/aes_block_uart_tx.sv
// Sends one 128-bit AES block as 16 back-to-back UART 8N1 bytes, byte 0 first.
// Holds the block shift register and byte index; bit timing lives in uart_tx_byte.
module aes_block_uart_tx
    import aes_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned NUM_BYTES    = AES_BLOCK_BITS / BYTE_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [0:AES_BLOCK_BITS-1] i_block,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic                      o_tx,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

    logic [0:AES_BLOCK_BITS-1] r_shift;
    logic [3:0]                r_byte_idx;
    logic                      r_busy;
    logic                      r_done;

    logic       w_accept;
    logic       w_last;
    logic       w_more;
    logic       w_byte_valid;
    logic       w_byte_ready;
    logic [7:0] w_byte_data;

    assign w_accept     = i_valid && !r_busy;
    assign w_last       = (r_byte_idx == LAST_IDX);
    assign w_more       = r_busy && !w_last;
    assign w_byte_valid = w_accept || w_more;
    // Byte 0 goes straight from the input so the start bit follows the accept edge.
    assign w_byte_data  = r_busy ? r_shift[BYTE_BITS:2*BYTE_BITS-1] : i_block[0:BYTE_BITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_shift    <= i_block;
                r_byte_idx <= '0;
                r_busy     <= 1'b1;
            end else if (r_busy && w_byte_ready) begin
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_byte_idx <= r_byte_idx + 4'd1;
                    r_shift    <= {r_shift[BYTE_BITS:AES_BLOCK_BITS-1], 8'h00};
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk    (clk),
        .rst    (rst),
        .i_valid(w_byte_valid),
        .i_data (w_byte_data),
        .o_ready(w_byte_ready),
        .o_tx   (o_tx)
    );

    assign o_ready = !r_busy;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_aes_block_uart_tx.sv
// Directed bench for aes_block_uart_tx: line decoder, done monitor, vector tables.
module tb_aes_block_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned CPB_L = 87;

    typedef struct {
        logic [0:127] blk;
        logic [7:0]   b0;
        logic [7:0]   b15;
    } blk_vec_t;

    typedef struct {
        logic       tx;
        logic [3:0] idx;
    } bit_vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [0:127] blk = '0;
    logic         vld = 1'b0;
    logic         rdy, tx, busy, done;
    logic [0:127] blk87 = '0;
    logic         vld87 = 1'b0;
    logic         rdy87, tx87, busy87, done87;

    int unsigned  cyc = 0;
    int           errors = 0;
    int           checks = 0;
    logic [7:0]   rx_q[$];
    int unsigned  done_q[$];
    int           rx_ferr = 0;
    logic [7:0]   rx_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_block_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES   (16)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .i_block(blk),
        .i_valid(vld),
        .o_ready(rdy),
        .o_tx   (tx),
        .o_busy (busy),
        .o_done (done)
    );

    aes_block_uart_tx #(
        .CLKS_PER_BIT(CPB_L),
        .NUM_BYTES   (16)
    ) u_dut87 (
        .clk    (clk),
        .rst    (rst),
        .i_block(blk87),
        .i_valid(vld87),
        .o_ready(rdy87),
        .o_tx   (tx87),
        .o_busy (busy87),
        .o_done (done87)
    );

    always @(negedge clk) if (done === 1'b1) done_q.push_back(cyc);

    // Line decoder: samples each bit near its middle, on falling clock edges.
    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                @(negedge clk);
                if (tx !== 1'b0) rx_ferr++;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    rx_b[k] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) rx_ferr++;
                rx_q.push_back(rx_b);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send_block(input logic [0:127] b, output int unsigned n);
        int unsigned w = 0;
        blk = b;
        vld = 1'b1;
        while (rdy !== 1'b1 && w < 2000) begin
            step();
            w++;
        end
        check("accept", {31'd0, rdy}, 32'd1);
        n = cyc;
        step();
        vld = 1'b0;
    endtask

    task automatic wait_done(output int unsigned dc);
        int unsigned w = 0;
        while (done !== 1'b1 && w < 1000) begin
            step();
            w++;
        end
        dc = cyc;
    endtask

    task automatic check_rx(input logic [0:127] b, input int base);
        for (int i = 0; i < 16; i++) begin
            if (rx_q.size() > base + i) check("rx byte", {24'd0, rx_q[base + i]}, {24'd0, b[8*i +: 8]});
            else check("rx byte missing", 32'd0, 32'd1);
        end
    endtask

    initial begin
        blk_vec_t    vec[4];
        bit_vec_t    fbits[10];
        int unsigned n, n1, n2, dc, d1, last;
        logic        prev;

        vec[0] = '{128'h3925841d02dc09fbdc118597196a0b32, 8'h39, 8'h32};
        vec[1] = '{128'h00112233445566778899aabbccddeeff, 8'h00, 8'hff};
        vec[2] = '{128'hffeeddccbbaa99887766554433221100, 8'hff, 8'h00};
        vec[3] = '{128'h0123456789abcdeffedcba9876543210, 8'h01, 8'h10};
        // First frame of 0x39: start, 1,0,0,1,1,1,0,0, stop.
        fbits[0] = '{1'b0, 4'd0}; fbits[1] = '{1'b1, 4'd1}; fbits[2] = '{1'b0, 4'd2};
        fbits[3] = '{1'b0, 4'd3}; fbits[4] = '{1'b1, 4'd4}; fbits[5] = '{1'b1, 4'd5};
        fbits[6] = '{1'b1, 4'd6}; fbits[7] = '{1'b0, 4'd7}; fbits[8] = '{1'b0, 4'd8};
        fbits[9] = '{1'b1, 4'd9};

        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("reset tx", {31'd0, tx}, 32'd1);
            check("reset ready", {31'd0, rdy}, 32'd1);
            check("reset busy", {31'd0, busy}, 32'd0);
            check("reset done", {31'd0, done}, 32'd0);
            step();
        end

        // Each table block sent alone: frame bits of block 0, done timing, bytes.
        for (int v = 0; v < 4; v++) begin
            rx_q.delete();
            done_q.delete();
            send_block(vec[v].blk, n);
            if (v == 0) begin
                for (int i = 0; i < 10; i++) begin
                    for (int j = 0; j < int'(CPB); j++) begin
                        check("first frame bit", {28'd0, fbits[i].idx}, {28'd0, fbits[i].idx});
                        checks--;
                        check("first frame tx", {31'd0, tx}, {31'd0, fbits[i].tx});
                        step();
                    end
                end
            end
            wait_done(dc);
            check("done at accept+641", dc, n + 641);
            repeat (4) step();
            check("rx count", rx_q.size(), 16);
            check_rx(vec[v].blk, 0);
            if (rx_q.size() == 16) begin
                check("rx first byte", {24'd0, rx_q[0]}, {24'd0, vec[v].b0});
                check("rx last byte", {24'd0, rx_q[15]}, {24'd0, vec[v].b15});
            end
            check("done pulses", done_q.size(), 1);
            check("idle ready", {31'd0, rdy}, 32'd1);
            check("idle tx", {31'd0, tx}, 32'd1);
        end

        // Busy ignore: a different block offered during byte 5.
        rx_q.delete();
        done_q.delete();
        send_block(vec[1].blk, n);
        while (cyc < n + 210) step();
        blk = vec[2].blk;
        vld = 1'b1;
        repeat (30) step();
        vld = 1'b0;
        blk = '0;
        wait_done(dc);
        check("busy ignore done", dc, n + 641);
        repeat (20) step();
        check("busy ignore pulses", done_q.size(), 1);
        check("busy ignore idle", {31'd0, busy}, 32'd0);
        check_rx(vec[1].blk, 0);

        // Back-to-back with i_valid held high.
        rx_q.delete();
        done_q.delete();
        blk = vec[2].blk;
        vld = 1'b1;
        check("b2b first ready", {31'd0, rdy}, 32'd1);
        n1 = cyc;
        step();
        blk = vec[3].blk;
        n2 = 0;
        while (rdy !== 1'b1 && n2 < 1000) begin
            step();
            n2++;
        end
        n2 = cyc;
        check("b2b accept in done cycle", n2, n1 + 641);
        check("b2b done with ready", {31'd0, done}, 32'd1);
        check("b2b idle gap tx", {31'd0, tx}, 32'd1);
        d1 = cyc;
        step();
        vld = 1'b0;
        blk = '0;
        check("b2b next start bit", {31'd0, tx}, 32'd0);
        wait_done(dc);
        check("b2b second done", dc, n2 + 641);
        // 640-cycle frame plus the single idle-high cycle.
        check("b2b done spacing", dc - d1, 641);
        repeat (4) step();
        check("b2b pulses", done_q.size(), 2);
        check("b2b rx count", rx_q.size(), 32);
        check_rx(vec[2].blk, 0);
        check_rx(vec[3].blk, 16);

        // Reset during byte 3 (0x67) bit 4.
        done_q.delete();
        send_block(vec[3].blk, n);
        while (cyc < n + 142) step();
        check("byte3 bit4 level", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        step();
        check("mid reset tx", {31'd0, tx}, 32'd1);
        check("mid reset ready", {31'd0, rdy}, 32'd1);
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (700) step();
        check("no done after reset", done_q.size(), 0);
        rx_q.delete();
        send_block(vec[0].blk, n);
        wait_done(dc);
        check("post reset done", dc, n + 641);
        repeat (4) step();
        check("post reset rx count", rx_q.size(), 16);
        check_rx(vec[0].blk, 0);
        check("framing errors", rx_ferr, 0);

        // Bit timing at 87 clocks per bit: every transition interval is a multiple of 87.
        blk87 = vec[0].blk;
        vld87 = 1'b1;
        n = 0;
        while (rdy87 !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        n = cyc;
        step();
        vld87 = 1'b0;
        check("87 start bit", {31'd0, tx87}, 32'd0);
        last = cyc;
        prev = tx87;
        n1 = 0;
        while (done87 !== 1'b1 && n1 < 15000) begin
            step();
            n1++;
            if (tx87 !== prev) begin
                check("87 bit interval", (cyc - last) % CPB_L, 0);
                last = cyc;
                prev = tx87;
            end
        end
        check("87 done", cyc, n + 1 + 160 * CPB_L);
        check("87 idle tx", {31'd0, tx87}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
